exception_unit: RTL and testbench

- Sequences exception entry and return for the single-cycle LEGv8 core.
- Sits downstream of the controller: consumes Exc, EStatus, ERet and ExtIAck; produces ExcAck and the level ExtIRQ the controller ORs into Exc.
- Synchronizes the raw external interrupt line and holds the pending request.
- Captures ELR/ESR, redirects fetch to the vector, restores the PC on ERet.

---
 rtl/exc_pkg.sv | 22 ++
 rtl/irq_sync.sv | 27 ++
 rtl/exception_unit.sv | 144 ++++++++++++++
 tb/tb_exception_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the LEGv8 exception unit.
package exc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTER,
        HANDLER,
        RETURN,
        FAULT
    } exc_state_t;

    localparam logic [3:0]  ESTAT_NONE    = 4'b0000;
    localparam logic [3:0]  ESTAT_IRQ     = 4'b0001;
    localparam logic [3:0]  ESTAT_INVALID = 4'b0010;

    localparam logic [63:0] VECTOR_ADDR_DEFAULT = 64'hD8;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchronizer for the raw interrupt line with a rising-edge
// detector; irq_rise is a single-cycle pulse per synchronized low->high edge.
module irq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_raw,
    output logic irq_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign irq_rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/exception_unit.sv
// Exception entry/return sequencer for the single-cycle LEGv8 core.
// Optional saturating entry counters are built when EXC_CNT_EN is defined.
module exception_unit
    import exc_pkg::*;
#(
    parameter int unsigned   N           = 64,
    parameter logic [N-1:0]  VECTOR_ADDR = N'(VECTOR_ADDR_DEFAULT),
    parameter int unsigned   SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         irq_raw,
    input  logic         Exc,
    input  logic [3:0]   EStatus,
    input  logic         ERet,
    input  logic         ExtIAck,
    input  logic [N-1:0] pc_curr,
    output logic         ExtIRQ,
    output logic         ExcAck,
    output logic         pc_redirect,
    output logic [N-1:0] pc_target,
    output logic         flush,
    output logic [N-1:0] ELR,
    output logic [3:0]   ESR,
    output logic         in_handler,
    output logic         double_fault
`ifdef EXC_CNT_EN
    ,
    output logic [15:0]  irq_count,
    output logic [15:0]  inv_count
`endif
);

    exc_state_t     state_q, state_d;
    logic           irq_rise;
    logic           irq_pending_q;
    logic [N-1:0]   elr_q;
    logic [3:0]     esr_q;

    irq_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk      (clk),
        .reset    (reset),
        .irq_raw  (irq_raw),
        .irq_rise (irq_rise)
    );

    // A new edge outranks a simultaneous acknowledge so no request is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_pending_q <= 1'b0;
        end else if (irq_rise) begin
            irq_pending_q <= 1'b1;
        end else if (ExtIAck) begin
            irq_pending_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            elr_q <= '0;
            esr_q <= '0;
        end else if (state_q == ENTER) begin
            elr_q <= pc_curr;
            esr_q <= EStatus;
        end
    end

    always_comb begin
        state_d      = state_q;
        ExcAck       = 1'b0;
        flush        = 1'b0;
        pc_redirect  = 1'b0;
        pc_target    = '0;
        in_handler   = 1'b0;
        double_fault = 1'b0;
        case (state_q)
            IDLE: begin
                if (Exc) begin
                    state_d = ENTER;
                end
            end
            ENTER: begin
                ExcAck      = 1'b1;
                flush       = 1'b1;
                pc_redirect = 1'b1;
                pc_target   = VECTOR_ADDR;
                state_d     = HANDLER;
            end
            HANDLER: begin
                in_handler = 1'b1;
                // An exception inside the handler is fatal even alongside ERET.
                if (Exc) begin
                    state_d = FAULT;
                end else if (ERet) begin
                    state_d = RETURN;
                end
            end
            RETURN: begin
                pc_redirect = 1'b1;
                pc_target   = elr_q;
                state_d     = IDLE;
            end
            FAULT: begin
                double_fault = 1'b1;
                pc_redirect  = 1'b1;
                pc_target    = VECTOR_ADDR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ExtIRQ = irq_pending_q & ~in_handler;
    assign ELR    = elr_q;
    assign ESR    = esr_q;

`ifdef EXC_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_count <= '0;
            inv_count <= '0;
        end else if (state_q == ENTER) begin
            if (EStatus == ESTAT_IRQ) begin
                irq_count <= sat_inc16(irq_count);
            end
            if (EStatus == ESTAT_INVALID) begin
                inv_count <= sat_inc16(inv_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit with a cycle-level reference model.
module tb_exception_unit;
    import exc_pkg::*;

    localparam int unsigned SS  = 2;
    localparam logic [63:0] VEC = 64'hD8;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        irq_raw  = 1'b0;
    logic        exc_drv  = 1'b0;
    logic        iack_drv = 1'b0;
    logic        loop_en  = 1'b0;
    logic        ERet     = 1'b0;
    logic [3:0]  EStatus  = 4'b0;
    logic [63:0] pc_curr  = 64'b0;
    logic        Exc, ExtIAck;

    logic        ExtIRQ, ExcAck, pc_redirect, flush, in_handler, double_fault;
    logic [63:0] pc_target, ELR;
    logic [3:0]  ESR;
`ifdef EXC_CNT_EN
    logic [15:0] irq_count, inv_count;
`endif

    int checks = 0;
    int errors = 0;

    // Controller loop: IRQ requests feed Exc, and acknowledge in the entry cycle.
    assign Exc     = exc_drv | (loop_en & ExtIRQ);
    assign ExtIAck = iack_drv | (loop_en & ExcAck & ExtIRQ);

    always #5 clk = ~clk;

    exception_unit #(
        .N           (64),
        .VECTOR_ADDR (VEC),
        .SYNC_STAGES (SS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_raw      (irq_raw),
        .Exc          (Exc),
        .EStatus      (EStatus),
        .ERet         (ERet),
        .ExtIAck      (ExtIAck),
        .pc_curr      (pc_curr),
        .ExtIRQ       (ExtIRQ),
        .ExcAck       (ExcAck),
        .pc_redirect  (pc_redirect),
        .pc_target    (pc_target),
        .flush        (flush),
        .ELR          (ELR),
        .ESR          (ESR),
        .in_handler   (in_handler),
        .double_fault (double_fault)
`ifdef EXC_CNT_EN
        ,
        .irq_count    (irq_count),
        .inv_count    (inv_count)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what the core is doing this cycle, as flags.
    bit          m_entering, m_handling, m_returning, m_fault, m_pend;
    logic [63:0] m_elr = '0;
    logic [3:0]  m_esr = '0;
    bit          raw_hist [0:SS];
    int          m_irqc, m_invc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_entering = 0; m_handling = 0; m_returning = 0; m_fault = 0; m_pend = 0;
            m_elr = '0; m_esr = '0; m_irqc = 0; m_invc = 0;
            for (int i = 0; i <= SS; i++) raw_hist[i] = 0;
        end else begin
            if (raw_hist[SS-1] && !raw_hist[SS]) m_pend = 1;
            else if (ExtIAck) m_pend = 0;
            for (int i = SS; i > 0; i--) raw_hist[i] = raw_hist[i-1];
            raw_hist[0] = irq_raw;

            if (m_fault) begin
                m_fault = 1;
            end else if (m_entering) begin
                m_elr = pc_curr;
                m_esr = EStatus;
                if (EStatus == 4'b0001 && m_irqc < 65535) m_irqc++;
                if (EStatus == 4'b0010 && m_invc < 65535) m_invc++;
                m_entering = 0;
                m_handling = 1;
            end else if (m_handling) begin
                if (Exc) begin
                    m_handling = 0;
                    m_fault = 1;
                end else if (ERet) begin
                    m_handling = 0;
                    m_returning = 1;
                end
            end else if (m_returning) begin
                m_returning = 0;
            end else if (Exc) begin
                m_entering = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("ExtIRQ",       ExtIRQ,       m_pend & ~m_handling);
        check("ExcAck",       ExcAck,       m_entering);
        check("flush",        flush,        m_entering);
        check("pc_redirect",  pc_redirect,  m_entering | m_returning | m_fault);
        check("pc_target",    pc_target,
              (m_entering || m_fault) ? VEC : (m_returning ? m_elr : 64'h0));
        check("ELR",          ELR,          m_elr);
        check("ESR",          ESR,          m_esr);
        check("in_handler",   in_handler,   m_handling);
        check("double_fault", double_fault, m_fault);
`ifdef EXC_CNT_EN
        check("irq_count",    irq_count,    m_irqc);
        check("inv_count",    inv_count,    m_invc);
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) step();
        check("rst_redirect", pc_redirect, 0);
        check("rst_elr", ELR, 0);
        check("rst_dfault", double_fault, 0);
        reset = 1'b1;

        // ERET outside a handler is ignored
        ERet = 1'b1;
        step();
        check("eret_idle_redirect", pc_redirect, 0);
        check("eret_idle_flush", flush, 0);
        check("eret_idle_handler", in_handler, 0);
        ERet = 1'b0;
        step();

        // Invalid opcode entry and return
        exc_drv = 1'b1; EStatus = ESTAT_INVALID; pc_curr = 64'h40;
        step();
        check("inv_ack", ExcAck, 1);
        check("inv_flush", flush, 1);
        check("inv_target", pc_target, 64'hD8);
        step();
        exc_drv = 1'b0; EStatus = ESTAT_NONE; pc_curr = 64'h44;
        check("inv_elr", ELR, 64'h40);
        check("inv_esr", ESR, 4'b0010);
        check("inv_in_handler", in_handler, 1);
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        check("ret_redirect", pc_redirect, 1);
        check("ret_target", pc_target, 64'h40);
        check("ret_flush", flush, 0);
        step();
        check("idle_redirect", pc_redirect, 0);

        // External IRQ through the controller loop
        loop_en = 1'b1; EStatus = ESTAT_IRQ; pc_curr = 64'h100;
        irq_raw = 1'b1;
        step();
        irq_raw = 1'b0;
        check("irq_lat1", ExtIRQ, 0);
        step();
        check("irq_lat2", ExtIRQ, 0);
        step();
        check("irq_lat3", ExtIRQ, 1);
        step();
        check("irq_enter_ack", ExcAck, 1);
        step();
        check("irq_esr", ESR, 4'b0001);
        check("irq_elr", ELR, 64'h100);
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        check("irq_pending_cleared", ExtIRQ, 0);
        step();
        check("irq_idle_ack", ExcAck, 0);

        // IRQ arriving inside the handler waits for ERET
        pc_curr = 64'h200;
        irq_raw = 1'b1;
        step();
        irq_raw = 1'b0;
        repeat (4) step();
        check("h_in_handler", in_handler, 1);
        check("h_elr", ELR, 64'h200);
        pc_curr = 64'h300;
        irq_raw = 1'b1;
        step();
        irq_raw = 1'b0;
        repeat (5) step();
        check("irq_masked", ExtIRQ, 0);
        ERet = 1'b1;
        step();
        ERet = 1'b0;
        check("ret2_redirect", pc_redirect, 1);
        check("ret2_target", pc_target, 64'h200);
        check("ret2_extirq", ExtIRQ, 1);
        step();
        step();
        check("second_entry_ack", ExcAck, 1);
        step();
        check("second_entry_elr", ELR, 64'h300);
        loop_en = 1'b0;
`ifdef EXC_CNT_EN
        check("cnt_irq3", irq_count, 3);
        check("cnt_inv1", inv_count, 1);
`endif

        // Exception inside the handler is fatal and sticky
        exc_drv = 1'b1; EStatus = ESTAT_INVALID; ERet = 1'b1;
        step();
        exc_drv = 1'b0; ERet = 1'b0; EStatus = ESTAT_NONE;
        check("df_set", double_fault, 1);
        check("df_esr_kept", ESR, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            ERet = (i == 1);
            exc_drv = (i == 2);
            step();
            check("df_target", pc_target, 64'hD8);
            check("df_sticky", double_fault, 1);
        end
        ERet = 1'b0; exc_drv = 1'b0;

        // Asynchronous reset out of FAULT
        #2 reset = 1'b0;
        #1;
        check("arst_dfault", double_fault, 0);
        check("arst_redirect", pc_redirect, 0);
        check("arst_target", pc_target, 0);
        check("arst_esr", ESR, 0);
        step();
        reset = 1'b1;
        step();
        check("post_rst_handler", in_handler, 0);

        // Reset mid-handler loses a pending IRQ
        exc_drv = 1'b1; EStatus = ESTAT_INVALID; pc_curr = 64'h80;
        step();
        step();
        exc_drv = 1'b0; EStatus = ESTAT_NONE;
        check("mh_in_handler", in_handler, 1);
        irq_raw = 1'b1;
        step();
        irq_raw = 1'b0;
        repeat (4) step();
        #2 reset = 1'b0;
        #1;
        check("mh_arst_handler", in_handler, 0);
        check("mh_arst_elr", ELR, 0);
        check("mh_arst_extirq", ExtIRQ, 0);
        step();
        reset = 1'b1;
        repeat (3) step();
        check("pending_lost", ExtIRQ, 0);
        check("mh_idle", in_handler, 0);
`ifdef EXC_CNT_EN
        check("cnt_after_rst", irq_count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
